elastic_pipe_buf: RTL and testbench

//   Parametrised elastic pipeline register: generalises the we/clr flip-flop into a

---
 rtl/elastic_pipe_buf.sv | 99 +++++++++
 tb/tb_elastic_pipe_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_buf.sv
// Elastic valid/ready pipeline buffer with DEPTH entries and synchronous flush.
// Optional stall statistics counter enabled by defining ELASTIC_BUF_STATS_EN.
module elastic_pipe_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ELASTIC_BUF_STATS_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;

    // Ready is a function of registered occupancy only, so a full buffer
    // never accepts on the same edge it pops.
    assign w_in_ready  = (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    assign w_wr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left stale on flush; out_data is masked while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

`ifdef ELASTIC_BUF_STATS_EN
    logic [15:0] r_stall_cnt;

    // Counts upstream back-pressure cycles; saturating, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_elastic_pipe_buf.sv
// Directed self-checking bench: DEPTH=2 instance (a) and DEPTH=3 instance (b).
module tb_elastic_pipe_buf;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_count;

`ifdef ELASTIC_BUF_STATS_EN
    logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elastic_pipe_buf #(.WIDTH(32), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
`ifdef ELASTIC_BUF_STATS_EN
        , .stall_cnt(a_stall_cnt)
`endif
    );

    elastic_pipe_buf #(.WIDTH(8), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
`ifdef ELASTIC_BUF_STATS_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_init: cnt=%0d ov=%b ir=%b od=%h want 0 0 1 0", a_count, a_out_valid, a_in_ready, a_out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        // load one entry then assert reset between edges
        a_in_valid = 1; a_in_data = 32'hDEAD_BEEF;
        tick();
        a_in_valid = 0;
        checks++;
        if (a_count !== 2'd1 || a_out_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_preload: cnt=%0d od=%h want 1 deadbeef", a_count, a_out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: cnt=%0d ov=%b ir=%b od=%h want 0 0 1 0", a_count, a_out_valid, a_in_ready, a_out_data);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'hA;
        tick();
        checks++;
        if (a_count !== 2'd1 || a_out_valid !== 1'b1 || a_out_data !== 32'hA) begin
            errors++;
            $display("FAIL fill_first: cnt=%0d ov=%b od=%h want 1 1 a", a_count, a_out_valid, a_out_data);
        end
        a_in_data = 32'hB;
        tick();
        checks++;
        if (a_count !== 2'd2 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: cnt=%0d ir=%b want 2 0", a_count, a_in_ready);
        end
        a_in_data = 32'hC;
        tick();
        checks++;
        if (a_count !== 2'd2 || a_out_data !== 32'hA) begin
            errors++;
            $display("FAIL fill_reject: cnt=%0d od=%h want 2 a", a_count, a_out_data);
        end
        a_in_valid = 0; a_out_ready = 1;
        tick();
        checks++;
        if (a_count !== 2'd1 || a_out_data !== 32'hB) begin
            errors++;
            $display("FAIL drain_second: cnt=%0d od=%h want 1 b", a_count, a_out_data);
        end
        tick();
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL drain_empty: cnt=%0d ov=%b od=%h want 0 0 0", a_count, a_out_valid, a_out_data);
        end
        a_out_ready = 0;
    endtask

    task automatic test_streaming();
        b_out_ready = 1;
        for (int i = 1; i <= 10; i++) begin
            b_in_valid = 1; b_in_data = 8'(i);
            tick();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== 8'(i) || b_count !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: ov=%b od=%0d cnt=%0d want 1 %0d 1", i, b_out_valid, b_out_data, b_count, i);
            end
        end
        b_in_valid = 0;
        tick();
        checks++;
        if (b_count !== 2'd0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: cnt=%0d ov=%b want 0 0", b_count, b_out_valid);
        end
        // fill to DEPTH=3 starting from a wrapped pointer, then drain
        b_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1; b_in_data = 8'(7 + i);
            tick();
        end
        b_in_valid = 0;
        checks++;
        if (b_count !== 2'd3 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full: cnt=%0d ir=%b want 3 0", b_count, b_in_ready);
        end
        b_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b_out_data !== 8'(7 + i)) begin
                errors++;
                $display("FAIL wrap_drain_%0d: od=%0d want %0d", i, b_out_data, 7 + i);
            end
            tick();
        end
        b_out_ready = 0;
        checks++;
        if (b_count !== 2'd0) begin
            errors++;
            $display("FAIL wrap_empty: cnt=%0d want 0", b_count);
        end
    endtask

    task automatic test_full_push_pop();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h1;
        tick();
        a_in_data = 32'h2;
        tick();
        a_in_data = 32'h3; a_out_ready = 1;
        tick();
        checks++;
        if (a_count !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 32'h2) begin
            errors++;
            $display("FAIL full_pp: cnt=%0d ir=%b od=%h want 1 1 2", a_count, a_in_ready, a_out_data);
        end
        a_in_valid = 0;
        tick();
        checks++;
        if (a_count !== 2'd0) begin
            errors++;
            $display("FAIL full_pp_drain: cnt=%0d want 0", a_count);
        end
        a_out_ready = 0;
    endtask

    task automatic test_flush();
        a_in_valid = 1; a_in_data = 32'h11;
        tick();
        a_in_data = 32'h22;
        tick();
        a_flush = 1; a_in_valid = 1; a_in_data = 32'h33; a_out_ready = 1;
        tick();
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: cnt=%0d ov=%b od=%h ir=%b want 0 0 0 1", a_count, a_out_valid, a_out_data, a_in_ready);
        end
        a_flush = 0; a_in_data = 32'h55; a_out_ready = 0;
        tick();
        a_in_valid = 0;
        checks++;
        if (a_count !== 2'd1 || a_out_valid !== 1'b1 || a_out_data !== 32'h55) begin
            errors++;
            $display("FAIL flush_after: cnt=%0d ov=%b od=%h want 1 1 55", a_count, a_out_valid, a_out_data);
        end
        a_out_ready = 1;
        tick();
        a_out_ready = 0;
    endtask

`ifdef ELASTIC_BUF_STATS_EN
    task automatic test_stats();
        idle_inputs();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        a_in_valid = 1; a_in_data = 32'h1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (a_stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_5: got %0d want 5", a_stall_cnt);
        end
        a_in_valid = 0; a_flush = 1;
        tick();
        a_flush = 0;
        checks++;
        if (a_stall_cnt !== 16'd5 || a_count !== 2'd0) begin
            errors++;
            $display("FAIL stall_flush: got %0d cnt=%0d want 5 0", a_stall_cnt, a_count);
        end
        a_in_valid = 1;
        tick();
        tick();
        for (int i = 0; i < 70000; i++) tick();
        a_in_valid = 0;
        checks++;
        if (a_stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_sat: got %h want ffff", a_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_push_pop();
        test_flush();
`ifdef ELASTIC_BUF_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
